// File: rtl/arm_board_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : arm_board_i2c_slave
// Purpose  : I2C target that assembles an 88-bit command frame from register
//            writes and answers reads with a 32-bit status word.
// Revision : 1.0 - initial release
// ============================================================================
module arm_board_i2c_slave #(
    parameter int FILTER_LEN = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  device_id,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [31:0] status_in,
    output logic [87:0] command_frame,
    output logic        frame_valid,
    output logic        busy,
    output logic        protocol_error
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ADDR   = 3'd1;
    localparam logic [2:0] c_REG    = 3'd2;
    localparam logic [2:0] c_WDATA  = 3'd3;
    localparam logic [2:0] c_RDATA  = 3'd4;
    localparam logic [2:0] c_IGNORE = 3'd5;
    localparam int         c_CW     = $clog2(FILTER_LEN + 1);

    logic [1:0]  w_raw;
    logic [1:0]  w_filt;
    logic [1:0]  r_filt_d;
    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [3:0]  r_bit_cnt;
    logic        r_ack_phase;
    logic [7:0]  r_shift;
    logic [31:0] r_tx;
    logic [7:0]  r_reg_idx;
    logic [1:0]  r_data_cnt;
    logic [15:0] r_seg;
    logic [87:0] r_staging;
    logic [87:0] r_frame;
    logic        r_sda_oe;
    logic        r_frame_valid;
    logic        r_perr;
    logic        r_busy;
    logic        w_sda_oe_next;
    logic        w_perr;
    logic        w_commit;
    logic        w_accept;

    assign w_raw = {sda_in, scl_in};

    // Index 0 is SCL, index 1 is SDA; level changes only after FILTER_LEN agreeing samples.
    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [1:0]      r_sync;
        logic [c_CW-1:0] r_cnt;
        logic            r_level;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_sync  <= 2'b11;
                r_cnt   <= '0;
                r_level <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], w_raw[g]};
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CW'(FILTER_LEN - 1)) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
        end
        assign w_filt[g] = r_level;
    end

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_bus_evt;
    logic w_rx_state, w_rx_bit, w_byte_done, w_ack_end, w_addr_match, w_reg_ok;

    assign w_scl        = w_filt[0];
    assign w_sda        = w_filt[1];
    assign w_scl_rise   = w_scl & ~r_filt_d[0];
    assign w_scl_fall   = ~w_scl & r_filt_d[0];
    assign w_start      = w_scl & r_filt_d[0] & ~w_sda & r_filt_d[1];
    assign w_stop       = w_scl & r_filt_d[0] & w_sda & ~r_filt_d[1];
    assign w_bus_evt    = w_start | w_stop;
    assign w_rx_state   = (r_state == c_ADDR) || (r_state == c_REG) || (r_state == c_WDATA);
    assign w_rx_bit     = w_rx_state && w_scl_rise && !r_ack_phase && (r_bit_cnt < 4'd8);
    assign w_byte_done  = w_rx_state && w_scl_fall && !r_ack_phase && (r_bit_cnt == 4'd8);
    assign w_ack_end    = w_rx_state && w_scl_fall && r_ack_phase;
    assign w_addr_match = (r_shift[7:1] == device_id);
    assign w_reg_ok     = (r_shift != 8'd0) && (r_shift <= 8'(NUM_REGS));

    always_comb begin
        case (r_state)
            c_ADDR:  w_accept = w_addr_match;
            c_REG:   w_accept = w_reg_ok;
            c_WDATA: w_accept = (r_data_cnt != 2'd3);
            default: w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = c_ADDR;
        end else if (w_stop) begin
            w_state_next = c_IDLE;
        end else if (w_byte_done && !w_accept) begin
            w_state_next = c_IGNORE;
        end else if (w_ack_end) begin
            if (r_state == c_ADDR) begin
                w_state_next = r_shift[0] ? c_RDATA : c_REG;
            end else if (r_state == c_REG) begin
                w_state_next = c_WDATA;
            end
        end else if (r_state == c_RDATA && w_scl_rise && r_bit_cnt == 4'd8 && w_sda) begin
            w_state_next = c_IGNORE;
        end
    end

    always_comb begin
        w_sda_oe_next = r_sda_oe;
        w_perr        = 1'b0;
        w_commit      = 1'b0;
        if (w_bus_evt) begin
            w_sda_oe_next = 1'b0;
            // A segment abandoned after at least one data byte is a truncated frame.
            w_perr = (r_state == c_WDATA) && (r_data_cnt == 2'd1 || r_data_cnt == 2'd2);
        end else if (w_byte_done) begin
            w_sda_oe_next = w_accept;
            w_perr        = !w_accept && (r_state != c_ADDR);
            w_commit      = (r_state == c_WDATA) && (r_data_cnt == 2'd2) && (r_reg_idx == 8'd4);
        end else if (w_ack_end) begin
            w_sda_oe_next = (r_state == c_ADDR) && r_shift[0] && !r_tx[31];
        end else if (r_state == c_RDATA && w_scl_fall) begin
            if (r_bit_cnt < 4'd7) begin
                w_sda_oe_next = !r_tx[30];
            end else if (r_bit_cnt == 4'd7) begin
                w_sda_oe_next = 1'b0;
            end else if (r_bit_cnt == 4'd9) begin
                w_sda_oe_next = !r_tx[31];
            end
        end else if (r_state == c_IDLE || r_state == c_IGNORE) begin
            w_sda_oe_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_filt_d      <= 2'b11;
            r_bit_cnt     <= '0;
            r_ack_phase   <= 1'b0;
            r_shift       <= '0;
            r_tx          <= '0;
            r_reg_idx     <= '0;
            r_data_cnt    <= '0;
            r_seg         <= '0;
            r_staging     <= '0;
            r_frame       <= '0;
            r_sda_oe      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_perr        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_filt_d      <= w_filt;
            r_sda_oe      <= w_sda_oe_next;
            r_frame_valid <= w_commit;
            r_perr        <= w_perr;
            if (w_bus_evt) begin
                r_bit_cnt   <= '0;
                r_ack_phase <= 1'b0;
                if (w_stop) begin
                    r_busy <= 1'b0;
                end
            end else begin
                if (w_rx_bit) begin
                    r_shift   <= {r_shift[6:0], w_sda};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (w_byte_done && w_accept) begin
                    r_ack_phase <= 1'b1;
                    case (r_state)
                        c_ADDR: begin
                            r_busy <= 1'b1;
                            r_tx   <= status_in;
                        end
                        c_REG: begin
                            r_reg_idx  <= r_shift;
                            r_data_cnt <= 2'd0;
                        end
                        default: begin
                            r_seg      <= {r_seg[7:0], r_shift};
                            r_data_cnt <= r_data_cnt + 2'd1;
                            if (r_data_cnt == 2'd2) begin
                                case (r_reg_idx)
                                    8'd1: r_staging[23:0]  <= {r_seg, r_shift};
                                    8'd2: r_staging[47:24] <= {r_seg, r_shift};
                                    8'd3: r_staging[71:48] <= {r_seg, r_shift};
                                    8'd4: begin
                                        // Byte 0 of register 4 is padding; only bytes 1,2 land.
                                        r_staging[87:72] <= {r_seg[7:0], r_shift};
                                        r_frame          <= {r_seg[7:0], r_shift, r_staging[71:0]};
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
                if (w_ack_end) begin
                    r_ack_phase <= 1'b0;
                    r_bit_cnt   <= '0;
                end
                if (r_state == c_RDATA) begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt < 4'd8) begin
                            r_tx      <= {r_tx[30:0], 1'b1};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (r_bit_cnt == 4'd9) begin
                            r_bit_cnt <= '0;
                        end
                    end else if (w_scl_rise && r_bit_cnt == 4'd8 && !w_sda) begin
                        r_bit_cnt <= 4'd9;
                    end
                end
            end
        end
    end

    assign sda_oe         = r_sda_oe;
    assign command_frame  = r_frame;
    assign frame_valid    = r_frame_valid;
    assign busy           = r_busy;
    assign protocol_error = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_arm_board_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_board_i2c_slave
// Purpose  : Self-checking bench driving an I2C master against the target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_board_i2c_slave;
    localparam int c_Q = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  device_id = 7'h12;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] status_in = 32'h0;
    logic [87:0] command_frame;
    logic        frame_valid;
    logic        busy;
    logic        protocol_error;

    assign sda_line = sda_m & ~sda_oe;

    arm_board_i2c_slave #(.FILTER_LEN(4), .NUM_REGS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .device_id      (device_id),
        .scl_in         (scl_m),
        .sda_in         (sda_line),
        .sda_oe         (sda_oe),
        .status_in      (status_in),
        .command_frame  (command_frame),
        .frame_valid    (frame_valid),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  regb;
        int          nbytes;
        logic [31:0] data;
        bit          addr_ack;
        bit          reg_ack;
        int          data_acks;
        int          perr;
        int          fv;
        logic [87:0] frame;
    } vec_t;

    vec_t        vecs[13];
    bit          ack_q[$];
    logic [7:0]  rd_q[$];
    logic [87:0] frame_q[$];
    int          checks = 0;
    int          errors = 0;
    int          perr_cnt = 0;
    int          fv_cnt = 0;
    bit          oe_seen = 1'b0;

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sda_oe) oe_seen = 1'b1;
        if (protocol_error) perr_cnt++;
        if (frame_valid) begin
            fv_cnt++;
            if (frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got 0x%0h expected no frame_valid", command_frame);
            end else begin
                check("frame_sb", command_frame, frame_q.pop_front());
            end
        end
    end

    task automatic wait_q(input int n);
        repeat (n * c_Q) @(posedge clock);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q(2);
        sda_m = 1'b0; wait_q(2);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(1); sda_m = 1'b0; wait_q(1); scl_m = 1'b1; wait_q(2);
        sda_m = 1'b1; wait_q(4);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wait_q(1); sda_m = b[i]; wait_q(1); scl_m = 1'b1; wait_q(2); scl_m = 1'b0;
        end
    endtask

    task automatic ack_bit(output bit ack);
        wait_q(1); sda_m = 1'b1; wait_q(1); scl_m = 1'b1; wait_q(1);
        ack = sda_oe;
        wait_q(1); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit exp_ack, input string name);
        bit ack;
        ack_q.push_back(exp_ack);
        send_bits(b);
        ack_bit(ack);
        check(name, 88'(ack), 88'(ack_q.pop_front()));
    endtask

    task automatic read_byte(input bit m_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wait_q(1); sda_m = 1'b1; wait_q(1); scl_m = 1'b1; wait_q(1);
            b[i] = sda_line;
            wait_q(1); scl_m = 1'b0;
        end
        wait_q(1); sda_m = ~m_ack; wait_q(1); scl_m = 1'b1; wait_q(2); scl_m = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        perr_cnt = 0; fv_cnt = 0; oe_seen = 1'b0;
        if (v.fv != 0) frame_q.push_back(v.frame);
        i2c_start();
        write_byte(v.addr, v.addr_ack, $sformatf("v%0d_addr_ack", k));
        check($sformatf("v%0d_busy", k), 88'(busy), 88'(v.addr_ack));
        write_byte(v.regb, v.addr_ack & v.reg_ack, $sformatf("v%0d_reg_ack", k));
        for (int i = 0; i < v.nbytes; i++) begin
            write_byte(v.data[31 - 8 * i -: 8], (i < v.data_acks), $sformatf("v%0d_data%0d_ack", k, i));
        end
        i2c_stop();
        check($sformatf("v%0d_busy_after_stop", k), 88'(busy), 88'(0));
        check($sformatf("v%0d_perr_pulses", k), 88'(perr_cnt), 88'(v.perr));
        check($sformatf("v%0d_fv_pulses", k), 88'(fv_cnt), 88'(v.fv));
        check($sformatf("v%0d_frame", k), command_frame, v.frame);
        if (!v.addr_ack) check($sformatf("v%0d_oe_quiet", k), 88'(oe_seen), 88'(0));
    endtask

    task automatic run_read(input logic [31:0] status, input int nbytes);
        logic [7:0] b;
        logic [39:0] stream;
        stream = {status, 8'hFF};
        status_in = status;
        i2c_start();
        write_byte(8'h25, 1'b1, "rd_addr_ack");
        check("rd_busy", 88'(busy), 88'(1));
        status_in = ~status;
        for (int i = 0; i < nbytes; i++) rd_q.push_back(stream[39 - 8 * i -: 8]);
        for (int i = 0; i < nbytes; i++) begin
            read_byte(i < nbytes - 1, b);
            check($sformatf("rd_byte%0d", i), 88'(b), 88'(rd_q.pop_front()));
        end
        wait_q(2);
        check("rd_release_after_nack", 88'(sda_oe), 88'(0));
        i2c_stop();
        check("rd_busy_after_stop", 88'(busy), 88'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h24, 8'h01, 3, 32'hA5B6C700, 1'b1, 1'b1, 3, 0, 0, 88'h0};
        vecs[1]  = '{8'h24, 8'h02, 3, 32'h11223300, 1'b1, 1'b1, 3, 0, 0, 88'h0};
        vecs[2]  = '{8'h24, 8'h03, 3, 32'h44556600, 1'b1, 1'b1, 3, 0, 0, 88'h0};
        vecs[3]  = '{8'h24, 8'h04, 3, 32'h00DEAD00, 1'b1, 1'b1, 3, 0, 1, 88'hDEAD_445566_112233_A5B6C7};
        vecs[4]  = '{8'h26, 8'h01, 3, 32'h01020300, 1'b0, 1'b0, 0, 0, 0, 88'hDEAD_445566_112233_A5B6C7};
        vecs[5]  = '{8'h24, 8'h07, 3, 32'hAABBCC00, 1'b1, 1'b0, 0, 1, 0, 88'hDEAD_445566_112233_A5B6C7};
        vecs[6]  = '{8'h24, 8'h02, 2, 32'h99990000, 1'b1, 1'b1, 2, 1, 0, 88'hDEAD_445566_112233_A5B6C7};
        vecs[7]  = '{8'h24, 8'h04, 3, 32'h00BEEF00, 1'b1, 1'b1, 3, 0, 1, 88'hBEEF_445566_112233_A5B6C7};
        vecs[8]  = '{8'h24, 8'h01, 4, 32'h01020304, 1'b1, 1'b1, 3, 1, 0, 88'hBEEF_445566_112233_A5B6C7};
        vecs[9]  = '{8'h24, 8'h00, 1, 32'h55000000, 1'b1, 1'b0, 0, 1, 0, 88'hBEEF_445566_112233_A5B6C7};
        vecs[10] = '{8'h24, 8'h05, 1, 32'h55000000, 1'b1, 1'b0, 0, 1, 0, 88'hBEEF_445566_112233_A5B6C7};
        vecs[11] = '{8'h24, 8'h04, 3, 32'h00123400, 1'b1, 1'b1, 3, 0, 1, 88'h1234_445566_112233_010203};
        vecs[12] = '{8'h24, 8'h04, 3, 32'h00ABCD00, 1'b1, 1'b1, 3, 0, 1, 88'hABCD_000000_000000_000000};

        repeat (5) @(posedge clock);
        #1;
        check("rst_sda_oe", 88'(sda_oe), 88'(0));
        check("rst_frame", command_frame, 88'h0);
        check("rst_frame_valid", 88'(frame_valid), 88'(0));
        check("rst_busy", 88'(busy), 88'(0));
        check("rst_perr", 88'(protocol_error), 88'(0));
        @(negedge clock);
        reset = 1'b0;
        wait_q(2);

        for (int k = 0; k < 12; k++) run_vec(k);

        run_read(32'hCAFE0123, 4);
        run_read(32'h89ABCDEF, 5);

        // Reset while the target is driving the address ACK low.
        i2c_start();
        send_bits(8'h24);
        wait_q(2);
        check("rst_mid_ack_driving", 88'(sda_oe), 88'(1));
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_async_oe", 88'(sda_oe), 88'(0));
        check("rst_async_frame", command_frame, 88'h0);
        check("rst_async_busy", 88'(busy), 88'(0));
        sda_m = 1'b1;
        repeat (4) @(posedge clock);
        #1 scl_m = 1'b1;
        repeat (20) @(posedge clock);
        perr_cnt = 0; fv_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        wait_q(2);
        check("post_rst_pulses", 88'(perr_cnt + fv_cnt), 88'(0));
        run_vec(12);

        check("frame_q_drained", 88'(frame_q.size()), 88'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_board_i2c_slave.md
Name: arm_board_i2c_slave

Overview:
- I2C target (responder) for an arm board. It is the other end of the command-frame transfers issued by the FPGA-side I2C master.
- Receives register writes 0x01..0x04, each carrying 3 data bytes, and assembles them into an 88-bit command frame. Commits the frame on completion of register 0x04.
- Answers read transactions with a 32-bit status word.
- Sits between the pad-level open-drain SDA/SCL buffers and the board's motor-command logic.

Parameters:
- FILTER_LEN, 4, number of consecutive identical samples required before a filtered SCL/SDA level changes (glitch filter).
- NUM_REGS, 4, highest valid write register index (valid range is 1..NUM_REGS).

Ports:
- clock  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-high reset.
- device_id  in  7  own 7-bit I2C address; sampled at each address byte.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- status_in  in  32  word returned on reads; latched at read-address ACK.
- command_frame  out  88  last committed frame.
- frame_valid  out  1  one-cycle pulse when command_frame updates.
- busy  out  1  high from an addressed START until STOP.
- protocol_error  out  1  one-cycle pulse on invalid register, byte overrun, or truncated frame.

Behaviour:
- Reset (async): sda_oe=0, command_frame=0, frame_valid=0, busy=0, protocol_error=0, staging=0, state=IDLE. Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - 2-flop synchronizer, then FILTER_LEN-sample filter on SCL and SDA.
  - Edge detect on the filtered signals.
  - Filtered-path latency: 2+FILTER_LEN clocks.
- START: SDA falls while SCL high → ADDR from any state, bit count cleared. This includes a repeated START.
- STOP: SDA rises while SCL high → IDLE from any state, busy=0, partial byte discarded, staging retained.
- Bit timing:
  - Sample SDA on SCL rising edge, MSB first.
  - Change sda_oe only on SCL falling edge.
  - ACK: assert sda_oe on the falling edge ending bit 8; release on the next falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr[7:1]==device_id → ACK, busy=1, then REG (rw=0) or RDATA (rw=1, latch status_in, byte index 0). Otherwise → IGNORE with no ACK.
  - REG: shift 8 bits.
    - Index 1..NUM_REGS → ACK, data count 0 → WDATA.
    - Otherwise → NACK, protocol_error pulse, IGNORE.
  - WDATA: shift 8 bits. Bytes 0,1,2 map to the segment MSB byte first.
    - reg1 → staging[23:0]
    - reg2 → staging[47:24]
    - reg3 → staging[71:48]
    - reg4: byte0 is pad (ignored); bytes 1,2 → staging[87:72]
    - Each of bytes 0..2 is ACKed.
    - A 4th byte is NACKed, pulses protocol_error, then → IGNORE.
  - Commit rule:
    - When reg4 byte 2 is ACKed (on the SCL falling edge starting its ACK bit): command_frame ← staging with the new bits merged; frame_valid=1 for exactly 1 clock.
    - Commit happens even if regs 1–3 were not rewritten.
    - STOP/START before a segment's 3rd byte → that segment's partial bytes are not written to staging; protocol_error pulse if ≥1 data byte had been received.
  - RDATA:
    - Drive status byte (3-idx) MSB first: sda_oe = ~bit.
    - Release SDA on the falling edge after bit 8; sample master ACK on the next rising edge.
    - ACK → idx+1; after idx 3, transmit 0xFF.
    - NACK → IGNORE.
  - IGNORE: sda_oe=0 until START/STOP.
- Simultaneous events: a START/STOP detected in the same clock as an SCL edge takes priority. Reset overrides everything.
- frame_valid and protocol_error never assert in the same clock as reset release.

Test Plan:
- Write 0x01 A5 B6 C7, 0x02 11 22 33, 0x03 44 55 66, 0x04 00 DE AD to device_id=0x12 (address byte 0x24) → all ACKed; one frame_valid pulse; command_frame=88'hDEAD_445566_112233_A5B6C7.
- Address byte 0x26 while device_id=0x12 → no ACK, sda_oe stays 0 for the whole transaction, busy=0, command_frame unchanged.
- Write to reg 0x07 → reg byte NACKed, protocol_error pulses once, no further ACKs until STOP.
- Read at 0x25 with status_in=32'hCAFE0123, master ACKs 3 bytes then NACKs the 4th → bytes on SDA CA,FE,01,23; sda_oe=0 after the NACK.
- Reg 0x02 write with 2 data bytes, then STOP → protocol_error pulse; staging[47:24] unchanged; a following full reg4 write commits the old [47:24].
- Assert reset while driving an ACK → sda_oe=0 asynchronously; all outputs return to reset values; the next START is handled normally.
